// File: rtl/float_sort_if.sv
// Valid/ready bundle for the three-value float sorter:
// upstream word feed and downstream sorted-triple handoff.
interface float_sort_if;
   localparam int FLEN = 64;

   logic                     up_valid;
   logic                     up_ready;
   logic [FLEN-1:0]          up_data;
   logic                     down_valid;
   logic                     down_ready;
   logic [0:2][FLEN-1:0]     sorted;
   logic                     err;

   modport slave (
      input  up_valid, up_data, down_ready,
      output up_ready, down_valid, sorted, err
   );

   modport master (
      output up_valid, up_data, down_ready,
      input  up_ready, down_valid, sorted, err
   );
endinterface

// File: rtl/float_triple_sort_fsm.sv
// Collects three FP64 words, sorts them in place with one shared
// comparator; FLOAT_SORT_DESCENDING_EN selects descending order.
module f_less_or_equal (
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic        res,
   output logic        err
);
   logic nan_a, nan_b, zeros;

   always_comb begin
      nan_a = (&a[62:52]) && (|a[51:0]);
      nan_b = (&b[62:52]) && (|b[51:0]);
      zeros = ~(|a[62:0]) && ~(|b[62:0]);
      err   = nan_a || nan_b;
      res   = 1'b0;
      if (!err) begin
         if (zeros)
            res = 1'b1;
         else if (a[63] != b[63])
            res = a[63];
         else if (a[63])
            res = (a[62:0] >= b[62:0]);
         else
            res = (a[62:0] <= b[62:0]);
      end
   end
endmodule

module float_triple_sort_fsm (
   input  logic         clk,
   input  logic         rst_n,
   float_sort_if.slave  bus
);
   localparam int FLEN = 64;

   typedef enum logic [2:0] {
      LOAD, CMP01, CMP12, CMP01B, OUT
   } state_t;

   state_t          state, state_nxt;
   logic [1:0]      cnt;
   logic [FLEN-1:0] r [0:2];
   logic            err_q;
   logic [FLEN-1:0] op_a, op_b;
   logic            le_res, le_err;
   logic            in_cmp, load_fire, swap;

   f_less_or_equal u_le (
      .a   (op_a),
      .b   (op_b),
      .res (le_res),
      .err (le_err)
   );

   always_comb begin
      state_nxt = state;
      op_a      = r[0];
      op_b      = r[1];
      in_cmp    = 1'b0;
      load_fire = (state == LOAD) && bus.up_valid;
      unique case (state)
         LOAD:   if (load_fire && cnt == 2'd2)
                    state_nxt = CMP01;
         CMP01:  begin
                    in_cmp    = 1'b1;
                    state_nxt = CMP12;
                 end
         CMP12:  begin
                    in_cmp    = 1'b1;
                    op_a      = r[1];
                    op_b      = r[2];
                    state_nxt = CMP01B;
                 end
         CMP01B: begin
                    in_cmp    = 1'b1;
                    state_nxt = OUT;
                 end
         OUT:    if (bus.down_ready)
                    state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   // An erroring compare never reorders; equal operands never swap.
`ifdef FLOAT_SORT_DESCENDING_EN
   assign swap = in_cmp && !le_err && le_res && (op_a != op_b);
`else
   assign swap = in_cmp && !le_err && !le_res;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOAD;
         cnt   <= 2'd0;
         r[0]  <= '0;
         r[1]  <= '0;
         r[2]  <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load_fire) begin
            r[cnt] <= bus.up_data;
            if (cnt == 2'd2) begin
               cnt   <= 2'd0;
               err_q <= 1'b0;
            end else begin
               cnt <= cnt + 2'd1;
            end
         end
         if (in_cmp)
            err_q <= err_q | le_err;
         if (swap) begin
            if (state == CMP12) begin
               r[1] <= r[2];
               r[2] <= r[1];
            end else begin
               r[0] <= r[1];
               r[1] <= r[0];
            end
         end
      end
   end

   assign bus.up_ready   = (state == LOAD);
   assign bus.down_valid = (state == OUT);
   assign bus.sorted[0]  = r[0];
   assign bus.sorted[1]  = r[1];
   assign bus.sorted[2]  = r[2];
   assign bus.err        = err_q;
endmodule

// File: tb/tb_float_triple_sort_fsm.sv
// Directed-vector bench for float_triple_sort_fsm; expected
// orders follow the build's FLOAT_SORT_DESCENDING_EN setting.
module tb_float_triple_sort_fsm;
   localparam logic [63:0] P0  = 64'h0000000000000000;
   localparam logic [63:0] P1  = 64'h3FF0000000000000;
   localparam logic [63:0] P2  = 64'h4000000000000000;
   localparam logic [63:0] P3  = 64'h4008000000000000;
   localparam logic [63:0] P5  = 64'h4014000000000000;
   localparam logic [63:0] P6  = 64'h4018000000000000;
   localparam logic [63:0] P7  = 64'h401C000000000000;
   localparam logic [63:0] M1  = 64'hBFF0000000000000;
   localparam logic [63:0] QN  = 64'h7FF8000000000000;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   float_sort_if bus ();

   float_triple_sort_fsm dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [63:0] d);
      int k;
      k = 0;
      bus.up_valid = 1'b1;
      bus.up_data  = d;
      while (!bus.up_ready && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (k >= 50)
         check("push_timeout", 64'(k), 64'd0);
      @(posedge clk);
      #1;
      bus.up_valid = 1'b0;
      bus.up_data  = $urandom();
   endtask

   task automatic wait_out(input string tag);
      int n;
      n = 0;
      while (!bus.down_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(tag, 64'(n), 64'd3);
   endtask

   task automatic check_triple(input string tag,
                               input logic [63:0] e0,
                               input logic [63:0] e1,
                               input logic [63:0] e2);
      check({tag, "_s0"}, bus.sorted[0], e0);
      check({tag, "_s1"}, bus.sorted[1], e1);
      check({tag, "_s2"}, bus.sorted[2], e2);
   endtask

   task automatic drain(input string tag);
      bus.down_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.down_ready = 1'b0;
      check({tag, "_dv_after"}, 64'(bus.down_valid), 64'd0);
      check({tag, "_ur_after"}, 64'(bus.up_ready), 64'd1);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      bus.up_valid   = 1'b0;
      bus.up_data    = '0;
      bus.down_ready = 1'b0;

      // reset with random noise on the inputs
      for (int i = 0; i < 4; i++) begin
         bus.up_valid   = 1'($urandom());
         bus.up_data    = {$urandom(), $urandom()};
         bus.down_ready = 1'($urandom());
         @(posedge clk);
         #1;
      end
      bus.up_valid   = 1'b0;
      bus.down_ready = 1'b0;
      rst_n = 1'b1;
      #2;
      check("rst_up_ready", 64'(bus.up_ready), 64'd1);
      check("rst_down_valid", 64'(bus.down_valid), 64'd0);
      check("rst_err", 64'(bus.err), 64'd0);
      check_triple("rst", P0, P0, P0);
      @(posedge clk);
      #1;

      // 3.0, -1.0, 2.0 back to back
      push(P3);
      push(M1);
      push(P2);
      check("asc_dv_T", 64'(bus.down_valid), 64'd0);
      wait_out("asc_latency");
`ifdef FLOAT_SORT_DESCENDING_EN
      check_triple("asc", P3, P2, M1);
`else
      check_triple("asc", M1, P2, P3);
`endif
      check("asc_err", 64'(bus.err), 64'd0);
      drain("asc");

      // duplicates with 5 cycles of backpressure; junk up_data ignored
      push(P1);
      push(P1);
      push(P0);
      wait_out("dup_latency");
      for (int i = 0; i < 5; i++) begin
         bus.up_valid = 1'b1;
         bus.up_data  = P7;
`ifdef FLOAT_SORT_DESCENDING_EN
         check_triple("dup_hold", P1, P1, P0);
`else
         check_triple("dup_hold", P0, P1, P1);
`endif
         check("dup_hold_ur", 64'(bus.up_ready), 64'd0);
         check("dup_hold_dv", 64'(bus.down_valid), 64'd1);
         @(posedge clk);
         #1;
      end
      bus.up_valid = 1'b0;
      drain("dup");

      // NaN: every compare touching it errs, so nothing moves
      bus.down_ready = 1'b1;
      push(P2);
      bus.down_ready = 1'b1;
      push(QN);
      push(P1);
      bus.down_ready = 1'b0;
      wait_out("nan_latency");
      check("nan_err", 64'(bus.err), 64'd1);
      check_triple("nan", P2, QN, P1);
      drain("nan");

      // partial triple survives a gap in up_valid
      push(M1);
      repeat (4) @(posedge clk);
      #1;
      check("gap_ur", 64'(bus.up_ready), 64'd1);
      push(P3);
      push(P2);
      wait_out("gap_latency");
`ifdef FLOAT_SORT_DESCENDING_EN
      check_triple("gap", P3, P2, M1);
`else
      check_triple("gap", M1, P2, P3);
`endif
      check("gap_err", 64'(bus.err), 64'd0);
      drain("gap");

      // reset during CMP12 discards the triple
      push(P5);
      push(P6);
      push(P7);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      check("mid_rst_ur", 64'(bus.up_ready), 64'd1);
      check("mid_rst_dv", 64'(bus.down_valid), 64'd0);
      check_triple("mid_rst", P0, P0, P0);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      push(P3);
      push(P2);
      push(P1);
      wait_out("post_rst_latency");
`ifdef FLOAT_SORT_DESCENDING_EN
      check_triple("post_rst", P3, P2, P1);
`else
      check_triple("post_rst", P1, P2, P3);
`endif
      check("post_rst_err", 64'(bus.err), 64'd0);
      drain("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1);
   end
endmodule
